// File: rtl/fp_stream_accumulator.sv
// Valid/ready front end that folds a stream of binary32 elements through an external combinational FPAdder.
// Optional sticky NaN/Inf classification of the running sum is enabled by defining FPACC_CLASSIFY_EN.
module fp_stream_accumulator #(
  parameter int XLEN    = 32,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [XLEN-1:0]    in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [XLEN-1:0]    add_a,
  output logic [XLEN-1:0]    add_b,
  input  logic [XLEN-1:0]    add_result,
  output logic [XLEN-1:0]    sum_data,
  output logic [COUNT_W-1:0] sum_count,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic               sum_nan,
  output logic               sum_inf
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

  state_t            state;
  state_t            state_next;
  logic [XLEN-1:0]   acc;
  logic [COUNT_W-1:0] count;
  logic              accept;
  logic [XLEN-1:0]   acc_next;

  assign in_ready  = (state != DONE);
  assign accept    = in_valid & in_ready;
  assign add_a     = acc;
  assign add_b     = in_data;
  assign sum_valid = (state == DONE);
  assign sum_data  = acc;
  assign sum_count = count;

  // The first element of a vector skips the adder so -0.0 and lone values stay bit-exact.
  assign acc_next = (state == IDLE) ? in_data : add_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          state_next = in_last ? DONE : ACCUM;
        end
      end
      DONE: begin
        if (sum_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      count <= '0;
    end else if (accept) begin
      acc <= acc_next;
      if (state == IDLE) begin
        count <= COUNT_W'(1);
      end else if (count != COUNT_MAX) begin
        count <= count + COUNT_W'(1);
      end
    end
  end

`ifdef FPACC_CLASSIFY_EN
  logic nan_q;
  logic inf_q;
  logic val_nan;
  logic val_inf;

  assign val_nan = (acc_next[30:23] == 8'hFF) && (acc_next[22:0] != 23'd0);
  assign val_inf = (acc_next[30:23] == 8'hFF) && (acc_next[22:0] == 23'd0);

  // Flags restart with the first element, so clearing on IDLE entry and the fresh load agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_q <= 1'b0;
      inf_q <= 1'b0;
    end else if (state == DONE && sum_ready) begin
      nan_q <= 1'b0;
      inf_q <= 1'b0;
    end else if (accept) begin
      if (state == IDLE) begin
        nan_q <= val_nan;
        inf_q <= val_inf;
      end else begin
        nan_q <= nan_q | val_nan;
        inf_q <= inf_q | val_inf;
      end
    end
  end

  assign sum_nan = nan_q;
  assign sum_inf = inf_q;
`else
  assign sum_nan = 1'b0;
  assign sum_inf = 1'b0;
`endif

endmodule

// File: tb/tb_fp_stream_accumulator.sv
// Scoreboard bench for fp_stream_accumulator with a behavioural binary32 adder standing in for FPAdder.
// Flag expectations follow FPACC_CLASSIFY_EN when it is defined for the build.
module tb_fp_stream_accumulator;

  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [31:0]   data;
    logic [CW-1:0] count;
    logic          nan;
    logic          inf;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic [31:0]   add_result;
  logic [31:0]   sum_data;
  logic [CW-1:0] sum_count;
  logic          sum_valid;
  logic          sum_ready = 1'b0;
  logic          sum_nan;
  logic          sum_inf;

  int          checks = 0;
  int          passed = 0;
  bit          hold_ready = 1'b0;
  logic [31:0] vec[$];
  exp_t        sb[$];

  logic [31:0]   prev_data;
  logic [CW-1:0] prev_count;
  logic          prev_valid = 1'b0;
  logic          prev_hs = 1'b0;

  fp_stream_accumulator #(.XLEN(32), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_result(add_result),
    .sum_data(sum_data), .sum_count(sum_count), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .sum_nan(sum_nan), .sum_inf(sum_inf)
  );

  always #5 clk = ~clk;

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic bit is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  function automatic bit is_inf(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
  endfunction

  function automatic real to_real(input logic [31:0] b);
    real m;
    if (b[30:23] == 8'd0) m = real'(b[22:0]) * pow2(-149);
    else m = (1.0 + real'(b[22:0]) / 8388608.0) * pow2(int'(b[30:23]) - 127);
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] to_bits(input real r);
    logic s;
    real  m;
    int   e = 0;
    int   frac;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    m = s ? -r : r;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0) begin m = m * 2.0; e--; end
    frac = $rtoi((m - 1.0) * 8388608.0 + 0.5);
    return {s, 8'(e + 127), 23'(frac)};
  endfunction

  // Stand-in for the external combinational FPAdder.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (is_nan(a) || is_nan(b)) return 32'h7FC00000;
    if (is_inf(a) && is_inf(b) && (a[31] != b[31])) return 32'h7FC00000;
    if (is_inf(a)) return a;
    if (is_inf(b)) return b;
    return to_bits(to_real(a) + to_real(b));
  endfunction

  always_comb add_result = fadd(add_a, add_b);

  // Vector total from the mathematical sum plus IEEE special-value rules.
  function automatic exp_t model_vector();
    exp_t e;
    real  s = 0.0;
    bit   seen_nan = 0, pinf = 0, ninf = 0, inf_flag = 0;
    foreach (vec[i]) begin
      if (is_nan(vec[i])) seen_nan = 1;
      else if (is_inf(vec[i])) begin
        if (!seen_nan) inf_flag = 1;
        if (vec[i][31]) ninf = 1; else pinf = 1;
        if (pinf && ninf) seen_nan = 1;
      end else s = s + to_real(vec[i]);
    end
    if (vec.size() == 1) e.data = vec[0];
    else if (seen_nan) e.data = 32'h7FC00000;
    else if (pinf) e.data = 32'h7F800000;
    else if (ninf) e.data = 32'hFF800000;
    else e.data = to_bits(s);
    e.count = (vec.size() > CMAX) ? CW'(CMAX) : CW'(vec.size());
`ifdef FPACC_CLASSIFY_EN
    e.nan = is_nan(e.data);
    e.inf = inf_flag;
`else
    e.nan = 1'b0;
    e.inf = 1'b0;
`endif
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, req, $time);
  endtask

  task automatic wait_ready();
    int b = 0;
    while (!in_ready && b < 200) begin
      @(posedge clk); #1;
      b++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  // Drives the elements in vec; the expected total enters the scoreboard once the last is accepted.
  task automatic applyStimulus(input bit gaps);
    exp_t e;
    e = model_vector();
    for (int i = 0; i < vec.size(); i++) begin
      in_data  = vec[i];
      in_last  = (i == vec.size() - 1);
      in_valid = 1'b1;
      wait_ready();
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'($urandom_range(0, 1));
      in_data  = $urandom;
      if (i == vec.size() - 1) begin
        sb.push_back(e);
        checkOutput("latency_sum_valid", 32'(sum_valid), 32'd1);
      end
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int b = 0;
    while ((sb.size() != 0 || sum_valid) && b < 500) begin
      @(posedge clk); #1;
      b++;
    end
    checkOutput("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      sum_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks DONE holds steady.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid <= 1'b0;
      prev_hs    <= 1'b0;
    end else begin
      if (sum_valid) begin
        checkOutput("done_in_ready", 32'(in_ready), 32'd0);
        if (prev_valid && !prev_hs) begin
          checkOutput("hold_data", sum_data, prev_data);
          checkOutput("hold_count", 32'(sum_count), 32'(prev_count));
        end
        if (sum_ready) begin
          if (sb.size() == 0) checkOutput("unexpected_sum", 32'(sb.size()), 32'd1);
          else begin
            e = sb.pop_front();
            checkOutput("sum_data", sum_data, e.data);
            checkOutput("sum_count", 32'(sum_count), 32'(e.count));
            checkOutput("sum_nan", 32'(sum_nan), 32'(e.nan));
            checkOutput("sum_inf", 32'(sum_inf), 32'(e.inf));
          end
        end
      end
      prev_valid <= sum_valid;
      prev_hs    <= sum_valid & sum_ready;
      prev_data  <= sum_data;
      prev_count <= sum_count;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_sum_valid", 32'(sum_valid), 32'd0);
    checkOutput("reset_acc", add_a, 32'd0);
    checkOutput("reset_count", 32'(sum_count), 32'd0);
    checkOutput("reset_flags", {30'd0, sum_nan, sum_inf}, 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    vec = {32'h3F800000, 32'h40000000, 32'h3F000000};
    applyStimulus(1'b0);
    vec = {32'hBF000000};
    applyStimulus(1'b0);
    vec = {32'h80000000};
    applyStimulus(1'b0);

    // Consumer stalls while the next element waits at the input.
    drain();
    hold_ready = 1'b1;
    @(posedge clk); #1;
    vec = {32'h3F800000};
    applyStimulus(1'b0);
    in_valid = 1'b1; in_data = 32'h40400000; in_last = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_valid", 32'(sum_valid), 32'd1);
    end
    hold_ready = 1'b0;
    vec = {32'h40400000};
    applyStimulus(1'b0);

    // Reset after two elements of an unfinished vector.
    drain();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = 32'h3F800000; in_last = 1'b0;
      wait_ready();
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_valid", 32'(sum_valid), 32'd0);
    checkOutput("midreset_acc", add_a, 32'd0);
    checkOutput("midreset_count", 32'(sum_count), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    vec = {32'h40000000};
    applyStimulus(1'b0);

    vec = {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    applyStimulus(1'b1);

    vec = {32'h7F800000, 32'h3F800000};
    applyStimulus(1'b0);
    vec = {32'h3F800000};
    applyStimulus(1'b0);
    vec = {32'h3F800000, 32'h7FC00001};
    applyStimulus(1'b0);

    for (int v = 0; v < 25; v++) begin
      vec.delete();
      repeat ($urandom_range(1, 6)) begin
        k = int'($urandom_range(0, 512)) - 256;
        vec.push_back(to_bits(real'(k) * 0.25));
      end
      applyStimulus(1'b1);
    end

    drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
